// File: rtl/timer_pkg.sv
// Shared definitions for the timer slice: FSM state encoding, BCD digit limits,
// digit positions on the 24-bit {m1,m0,s1,s0,c1,c0} bus and preset clamping.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    localparam int unsigned DIG_C0     = 0;
    localparam int unsigned DIG_C1     = 1;
    localparam int unsigned DIG_S0     = 2;
    localparam int unsigned DIG_S1     = 3;
    localparam int unsigned DIG_M0     = 4;
    localparam int unsigned DIG_M1     = 5;
    localparam int unsigned NUM_DIGITS = 6;

    // Minute tens keeps the full BCD range; the minute ceiling is enforced by saturation.
    localparam logic [23:0] DIGIT_LIMITS = {BCD_MAX, BCD_MAX, SEC_TENS_MAX,
                                            BCD_MAX, BCD_MAX, BCD_MAX};

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] clamp_preset(input logic [15:0] p,
                                                 input logic [7:0]  max_min_bcd);
        logic [7:0] mins;
        logic [3:0] s1;
        logic [3:0] s0;
        mins = {clamp_digit(p[15:12], BCD_MAX), clamp_digit(p[11:8], BCD_MAX)};
        s1   = clamp_digit(p[7:4], SEC_TENS_MAX);
        s0   = clamp_digit(p[3:0], BCD_MAX);
        // Valid BCD compares correctly as plain unsigned.
        if (mins > max_min_bcd) begin
            mins = max_min_bcd;
        end
        return {mins, s1, s0};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with configurable wrap limit, inc/dec enables, synchronous
// load and combinational carry/borrow out for chaining.
module bcd_digit_counter #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] q_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i) begin
            q_d = (q_q >= LIMIT) ? 4'd0 : q_q + 4'd1;
        end else if (dec_i) begin
            q_d = (q_q == 4'd0) ? LIMIT : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign carry_o  = inc_i && (q_q >= LIMIT);
    assign borrow_o = dec_i && (q_q == 4'd0);

endmodule

// File: rtl/timer_sequencer.sv
// Run/stop/mode sequencer for the stopwatch/countdown timer with BCD mm:ss.cc.
// Optional LAP_HOLD_EN: btn_clear in stopwatch RUN freezes/releases the display.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned MAX_MIN  = 59,
    parameter int unsigned PRESET_W = 16
) (
    input  logic                CLK_50MHz,
    input  logic                rst,
    input  logic                tick_100Hz,
    input  logic                btn_start,
    input  logic                btn_clear,
    input  logic                btn_mode,
    input  logic [PRESET_W-1:0] preset,
    output logic                mode_cd,
    output logic [23:0]         digits,
    output logic                running,
    output logic                expired
`ifdef LAP_HOLD_EN
    ,
    output logic                lap_active
`endif
);

    localparam logic [7:0]  MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [23:0] MAX_COUNT   = {MAX_MIN_BCD, 16'h5999};

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic        load;
    logic [23:0] load_val;
    logic [23:0] preset_cd;
    logic [23:0] count;
    logic        step_up, step_dn;
    logic [5:0]  carry, borrow;
    logic        at_zero, at_one_cs, at_max;

    assign preset_cd = {clamp_preset(preset, MAX_MIN_BCD), 8'h00};
    assign at_zero   = (count == '0);
    assign at_one_cs = (count == 24'h000001);
    assign at_max    = (count == MAX_COUNT);

`ifdef LAP_HOLD_EN
    logic        lap_q, lap_d;
    logic        lap_capture;
    logic [23:0] lap_digits_q;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        load     = 1'b0;
        load_val = mode_q ? preset_cd : '0;
        step_up  = 1'b0;
        step_dn  = 1'b0;
`ifdef LAP_HOLD_EN
        lap_d       = lap_q;
        lap_capture = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    load = 1'b1;
                end else if (btn_start) begin
                    if (!(mode_q && at_zero)) begin
                        state_d = RUN;
                    end
                end else if (btn_mode) begin
                    mode_d   = !mode_q;
                    load     = 1'b1;
                    load_val = mode_q ? '0 : preset_cd;
                end
            end
            RUN: begin
                if (btn_clear) begin
`ifdef LAP_HOLD_EN
                    if (!mode_q) begin
                        lap_d       = !lap_q;
                        lap_capture = !lap_q;
                    end else begin
                        state_d = IDLE;
                        load    = 1'b1;
                    end
`else
                    state_d = IDLE;
                    load    = 1'b1;
`endif
                end else if (btn_start) begin
                    state_d = PAUSE;
                end else if (tick_100Hz) begin
                    if (mode_q) begin
                        step_dn = !at_zero;
                        if (at_zero || at_one_cs) begin
                            state_d = DONE;
                        end
                    end else begin
                        step_up = !at_max;
                    end
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d = IDLE;
                    load    = 1'b1;
                end else if (btn_start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (btn_clear || btn_start) begin
                    state_d = IDLE;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LAP_HOLD_EN
        if (state_d == IDLE) begin
            lap_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK_50MHz) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter #(
            .LIMIT(DIGIT_LIMITS[4*i +: 4])
        ) u_digit (
            .clk_i     (CLK_50MHz),
            .rst_i     (rst),
            .load_i    (load),
            .load_val_i(load_val[4*i +: 4]),
            .inc_i     ((i == 0) ? step_up : carry[(i == 0) ? 0 : i-1]),
            .dec_i     ((i == 0) ? step_dn : borrow[(i == 0) ? 0 : i-1]),
            .q_o       (count[4*i +: 4]),
            .carry_o   (carry[i]),
            .borrow_o  (borrow[i])
        );
    end

    // Minute-tens carry/borrow never fires: saturation and DONE stop the chain first.
    logic unused_chain_top;
    assign unused_chain_top = carry[DIG_M1] ^ borrow[DIG_M1];

`ifdef LAP_HOLD_EN
    always_ff @(posedge CLK_50MHz) begin
        if (rst) begin
            lap_q        <= 1'b0;
            lap_digits_q <= '0;
        end else begin
            lap_q <= lap_d;
            if (lap_capture) begin
                lap_digits_q <= count;
            end
        end
    end

    assign lap_active = lap_q;
    assign digits     = lap_q ? lap_digits_q : count;
`else
    assign digits     = count;
`endif

    assign mode_cd = mode_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer (MAX_MIN=59 and MAX_MIN=1 instances)
// against a centisecond-integer reference model; also covers LAP_HOLD_EN builds.
module tb_timer_sequencer;

    logic        clk = 1'b0;
    logic        rst, tick, bs, bc, bm;
    logic [15:0] preset;
    logic        mode0, run0, exp0, mode1, run1, exp1;
    logic [23:0] dig0, dig1;
`ifdef LAP_HOLD_EN
    logic        lap0, lap1;
    localparam bit LAP_FEATURE = 1'b1;
`else
    localparam bit LAP_FEATURE = 1'b0;
`endif

    always #10 clk = ~clk;

    timer_sequencer #(.MAX_MIN(59), .PRESET_W(16)) dut0 (
        .CLK_50MHz(clk), .rst(rst), .tick_100Hz(tick), .btn_start(bs),
        .btn_clear(bc), .btn_mode(bm), .preset(preset), .mode_cd(mode0),
        .digits(dig0), .running(run0), .expired(exp0)
`ifdef LAP_HOLD_EN
        , .lap_active(lap0)
`endif
    );

    timer_sequencer #(.MAX_MIN(1), .PRESET_W(16)) dut1 (
        .CLK_50MHz(clk), .rst(rst), .tick_100Hz(tick), .btn_start(bs),
        .btn_clear(bc), .btn_mode(bm), .preset(preset), .mode_cd(mode1),
        .digits(dig1), .running(run1), .expired(exp1)
`ifdef LAP_HOLD_EN
        , .lap_active(lap1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time kept as total centiseconds.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_e;
    mst_e mst     [2] = '{M_IDLE, M_IDLE};
    bit   mmode   [2] = '{1'b0, 1'b0};
    int   mcs     [2] = '{0, 0};
    bit   mlap_on [2] = '{1'b0, 1'b0};
    int   mlap_cs [2] = '{0, 0};
    int   max_min [2] = '{59, 1};

    function automatic int preset_cs(input logic [15:0] p, input int mm);
        int d[4];
        int mins;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(p[4*i +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (d[1] > 5) d[1] = 5;
        mins = d[3] * 10 + d[2];
        if (mins > mm) mins = mm;
        return mins * 6000 + (d[1] * 10 + d[0]) * 100;
    endfunction

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_step(input int j, input bit t, input bit s, input bit c,
                              input bit m, input bit r);
        int pre, mx;
        pre = preset_cs(preset, max_min[j]);
        mx  = max_min[j] * 6000 + 5999;
        if (r) begin
            mst[j] = M_IDLE; mmode[j] = 1'b0; mcs[j] = 0;
        end else begin
            case (mst[j])
                M_IDLE: begin
                    if (c) mcs[j] = mmode[j] ? pre : 0;
                    else if (s) begin
                        if (!(mmode[j] && mcs[j] == 0)) mst[j] = M_RUN;
                    end else if (m) begin
                        mmode[j] = !mmode[j];
                        mcs[j]   = mmode[j] ? pre : 0;
                    end
                end
                M_RUN: begin
                    if (c && LAP_FEATURE && !mmode[j]) begin
                        if (!mlap_on[j]) mlap_cs[j] = mcs[j];
                        mlap_on[j] = !mlap_on[j];
                    end else if (c) begin
                        mst[j] = M_IDLE; mcs[j] = mmode[j] ? pre : 0;
                    end else if (s) mst[j] = M_PAUSE;
                    else if (t) begin
                        if (mmode[j]) begin
                            if (mcs[j] > 0) mcs[j]--;
                            if (mcs[j] == 0) mst[j] = M_DONE;
                        end else if (mcs[j] < mx) mcs[j]++;
                    end
                end
                M_PAUSE: begin
                    if (c) begin
                        mst[j] = M_IDLE; mcs[j] = mmode[j] ? pre : 0;
                    end else if (s) mst[j] = M_RUN;
                end
                M_DONE: begin
                    if (c || s) begin
                        mst[j] = M_IDLE; mcs[j] = pre;
                    end
                end
            endcase
        end
        if (mst[j] == M_IDLE) mlap_on[j] = 1'b0;
    endtask

    function automatic logic [23:0] exp_digits(input int j);
        return to_bcd(mlap_on[j] ? mlap_cs[j] : mcs[j]);
    endfunction

    task automatic compare_all();
        check("dig0",  32'(dig0),  32'(exp_digits(0)));
        check("run0",  32'(run0),  32'(mst[0] == M_RUN));
        check("exp0",  32'(exp0),  32'(mst[0] == M_DONE));
        check("mode0", 32'(mode0), 32'(mmode[0]));
        check("dig1",  32'(dig1),  32'(exp_digits(1)));
        check("run1",  32'(run1),  32'(mst[1] == M_RUN));
        check("exp1",  32'(exp1),  32'(mst[1] == M_DONE));
        check("mode1", 32'(mode1), 32'(mmode[1]));
`ifdef LAP_HOLD_EN
        check("lap0",  32'(lap0),  32'(mlap_on[0]));
        check("lap1",  32'(lap1),  32'(mlap_on[1]));
`endif
    endtask

    task automatic cyc(input bit t, input bit s, input bit c, input bit m, input bit r);
        tick = t; bs = s; bc = c; bm = m; rst = r;
        @(posedge clk);
        for (int j = 0; j < 2; j++) model_step(j, t, s, c, m, r);
        #1;
        tick = 1'b0; bs = 1'b0; bc = 1'b0; bm = 1'b0; rst = 1'b0;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        tick = 1'b0; bs = 1'b0; bc = 1'b0; bm = 1'b0; rst = 1'b0; preset = '0;
        #5;
        cyc(0, 0, 0, 0, 1);
        check("rst_digits", 32'(dig0), 32'h0);
        check("rst_flags",  32'({mode0, run0, exp0}), 32'h0);

        // Stopwatch counting, minute carry and saturation (dut1 tops out at 01:59.99).
        cyc(0, 1, 0, 0, 0);
        ticks(150);
        check("sw_150", 32'(dig0), 32'h000150);
        check("sw_run", 32'({run0, exp0}), 32'b10);
        ticks(5849);
        check("sw_5999", 32'(dig0), 32'h005999);
        ticks(1);
        check("sw_min_carry", 32'(dig0), 32'h010000);
        ticks(5999);
        check("sat_reach", 32'(dig1), 32'h015999);
        ticks(5);
        check("sat_hold", 32'(dig1), 32'h015999);
        check("sat_run",  32'(run1), 32'h1);
        check("sw_12004", 32'(dig0), 32'h020004);

        // Pause holds, resume continues; start+tick same cycle does not step.
        cyc(0, 1, 0, 0, 0);
        ticks(50);
        check("pause_hold", 32'(dig0), 32'h020004);
        cyc(0, 1, 0, 0, 0);
        ticks(10);
        check("resume_10", 32'(dig0), 32'h020014);
        cyc(1, 1, 0, 0, 0);
        check("btn_tick_dig", 32'(dig0), 32'h020014);
        check("btn_tick_run", 32'(run0), 32'h0);
        cyc(0, 0, 1, 0, 0);
        check("clear_sw", 32'(dig0), 32'h0);

        // Countdown from 00:03.00 to DONE.
        preset = 16'h0003;
        cyc(0, 0, 0, 1, 0);
        check("cd_load", 32'(dig0), 32'h000300);
        cyc(0, 1, 0, 0, 0);
        ticks(299);
        check("cd_last", 32'(dig0), 32'h000001);
        ticks(1);
        check("cd_zero", 32'(dig0), 32'h0);
        check("cd_done", 32'({run0, exp0}), 32'b01);
        cyc(0, 0, 1, 0, 0);
        check("cd_reload", 32'(dig0), 32'h000300);
        check("cd_idle", 32'(exp0), 32'h0);

        // Mode button ignored in RUN.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("mode_in_run", 32'(mode0), 32'h1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Zero preset: start refused.
        preset = 16'h0000;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("zero_start", 32'(run0), 32'h0);

        // Invalid preset digits clamp; minute ceiling differs per instance.
        preset = 16'h7A6B;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("clamp0", 32'(dig0), 32'h595900);
        check("clamp1", 32'(dig1), 32'h015900);

        // DONE left via start; clear beats start in RUN.
        preset = 16'h0001;
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(100);
        check("done_1s", 32'(exp0), 32'h1);
        cyc(0, 1, 0, 0, 0);
        check("done_start", 32'(dig0), 32'h000100);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check("clr_beats_start", 32'({run0, dig0}), 32'h000100);

        // Reset mid-run.
        cyc(0, 1, 0, 0, 0);
        ticks(7);
        cyc(0, 0, 0, 0, 1);
        check("rst_mid_run", 32'({mode0, run0, exp0, dig0}), 32'h0);

`ifdef LAP_HOLD_EN
        cyc(0, 1, 0, 0, 0);
        ticks(200);
        cyc(0, 0, 1, 0, 0);
        check("lap_on", 32'({lap0, dig0}), 32'h1000200);
        ticks(100);
        check("lap_hold", 32'(dig0), 32'h000200);
        cyc(0, 0, 1, 0, 0);
        check("lap_release", 32'({lap0, dig0}), 32'h000300);
`endif

        // Randomised phase.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 3) == 0) preset = 16'($urandom());
                else preset = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            end
            cyc(1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 23) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
